// File: rtl/tt_bist_harness.sv
// Self-test harness: LFSR stimulus onto the user project, MISR compaction of its response.
// Latency: first vector on dut_in one cycle after accepted start; done one cycle after last capture.
// Backpressure: none; start is ignored while running, abort cancels immediately and wins over start.
module tt_bist_harness #(
    parameter int                 IN_W      = 8,
    parameter int                 OUT_W     = 8,
    parameter int                 N_VECT    = 256,
    parameter int                 SETTLE    = 1,
    parameter logic [IN_W-1:0]    LFSR_POLY = 8'hB8,
    parameter logic [OUT_W-1:0]   MISR_POLY = 8'hB8,
    localparam int                CW        = $clog2(N_VECT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IN_W-1:0]       cfg_seed,
    input  logic [OUT_W-1:0]      dut_out,
    output logic [IN_W-1:0]       dut_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      signature,
    output logic [CW-1:0]         vec_count
);

    // hold counter only needs to reach SETTLE; keep at least one bit when SETTLE is 0
    localparam int            HW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(SETTLE);
    localparam logic [CW-1:0] LAST_VEC = CW'(N_VECT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   lfsr_q, lfsr_d;
    logic [OUT_W-1:0]  misr_q, misr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     vec_count_q, vec_count_d;
    logic [OUT_W-1:0]  signature_q, signature_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IN_W-1:0]   seed_eff;
    logic [IN_W-1:0]   lfsr_next;
    logic [OUT_W-1:0]  misr_next;

    // a zero seed would lock the LFSR at zero, so it is replaced by 1
    assign seed_eff  = (cfg_seed == '0) ? IN_W'(1) : cfg_seed;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
    assign misr_next = (misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0) ^ dut_out;

    // next-state and registered-output computation; abort overrides everything
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        misr_d      = misr_q;
        hold_d      = hold_q;
        vec_count_d = vec_count_q;
        signature_d = signature_q;
        dut_in_d    = dut_in_q;
        busy_d      = busy_q;
        done_d      = done_q;

        if (abort) begin
            state_d  = ST_IDLE;
            dut_in_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_RUN;
                        lfsr_d      = seed_eff;
                        misr_d      = '0;
                        vec_count_d = '0;
                        hold_d      = '0;
                        dut_in_d    = seed_eff;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (hold_q == HOLD_MAX) begin
                        misr_d      = misr_next;
                        lfsr_d      = lfsr_next;
                        vec_count_d = vec_count_q + CW'(1);
                        hold_d      = '0;
                        if (vec_count_q == LAST_VEC) begin
                            state_d     = ST_DONE;
                            signature_d = misr_next;
                            dut_in_d    = '0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            dut_in_d = lfsr_next;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    dut_in_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                end
            endcase
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= '0;
            misr_q      <= '0;
            hold_q      <= '0;
            vec_count_q <= '0;
            signature_q <= '0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            misr_q      <= misr_d;
            hold_q      <= hold_d;
            vec_count_q <= vec_count_d;
            signature_q <= signature_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = signature_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: four instances with different vector counts and settle times.
// Directed stimulus, hand-computed expected stimulus sequences and signatures.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_tt_bist_harness;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] seed;

    // a: N=4 S=0, response = ~stimulus ; b: N=1 loopback ; c: N=2 loopback ; d: N=2 S=2, response 0
    logic [7:0] dut_in_a, dut_in_b, dut_in_c, dut_in_d;
    logic [7:0] dut_out_a, dut_out_b, dut_out_c, dut_out_d;
    logic [7:0] sig_a, sig_b, sig_c, sig_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;
    logic [2:0] vc_a;
    logic [0:0] vc_b;
    logic [1:0] vc_c;
    logic [1:0] vc_d;

    assign dut_out_a = ~dut_in_a;
    assign dut_out_b = dut_in_b;
    assign dut_out_c = dut_in_c;
    assign dut_out_d = 8'h00;

    tt_bist_harness #(.IN_W(8), .OUT_W(8), .N_VECT(4), .SETTLE(0)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_seed(seed),
        .dut_out(dut_out_a), .dut_in(dut_in_a), .busy(busy_a), .done(done_a),
        .signature(sig_a), .vec_count(vc_a));

    tt_bist_harness #(.IN_W(8), .OUT_W(8), .N_VECT(1), .SETTLE(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_seed(seed),
        .dut_out(dut_out_b), .dut_in(dut_in_b), .busy(busy_b), .done(done_b),
        .signature(sig_b), .vec_count(vc_b));

    tt_bist_harness #(.IN_W(8), .OUT_W(8), .N_VECT(2), .SETTLE(0)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_seed(seed),
        .dut_out(dut_out_c), .dut_in(dut_in_c), .busy(busy_c), .done(done_c),
        .signature(sig_c), .vec_count(vc_c));

    tt_bist_harness #(.IN_W(8), .OUT_W(8), .N_VECT(2), .SETTLE(2)) u_d (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_seed(seed),
        .dut_out(dut_out_d), .dut_in(dut_in_d), .busy(busy_d), .done(done_d),
        .signature(sig_d), .vec_count(vc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seq [4];
    logic [7:0] seq_a [$];
    int nb_a, nb_b, nb_c, nb_d;
    int done_at_a;

    initial begin
        exp_seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        nb_a = 0; nb_b = 0; nb_c = 0; nb_d = 0;
        done_at_a = -1;

        // reset with random inputs
        rst   = 1'b1;
        start = 1'($urandom);
        abort = 1'($urandom);
        seed  = 8'($urandom);
        repeat (2) tick();
        check_eq("rst_dut_in", 32'(dut_in_a), 32'h0);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        check_eq("rst_done", 32'(done_a), 32'h0);
        check_eq("rst_sig", 32'(sig_a), 32'h0);
        check_eq("rst_vc", 32'(vc_a), 32'h0);
        check_eq("rst_busy_d", 32'(busy_d), 32'h0);

        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        tick();
        check_eq("idle_busy", 32'(busy_a), 32'h0);

        // main run, start held one extra cycle into RUN to confirm it is ignored
        seed  = 8'h01;
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (busy_a) seq_a.push_back(dut_in_a);
            if (done_a && done_at_a < 0) done_at_a = i;
            nb_a += int'(busy_a);
            nb_b += int'(busy_b);
            nb_c += int'(busy_c);
            nb_d += int'(busy_d);
            if (i == 1) start = 1'b0;
            tick();
        end
        check_eq("len_a", 32'(nb_a), 32'd4);
        check_eq("len_b", 32'(nb_b), 32'd1);
        check_eq("len_c", 32'(nb_c), 32'd2);
        check_eq("len_settle_d", 32'(nb_d), 32'd6);
        check_eq("seq_size", 32'(seq_a.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < seq_a.size()) check_eq($sformatf("seq_%0d", k), 32'(seq_a[k]), 32'(exp_seq[k]));
        end
        check_eq("done_at_a", 32'(done_at_a), 32'd4);
        check_eq("done_a", 32'(done_a), 32'h1);
        check_eq("done_dut_in", 32'(dut_in_a), 32'h0);
        check_eq("sig_a", 32'(sig_a), 32'h36);
        check_eq("vc_a", 32'(vc_a), 32'd4);
        check_eq("sig_loop1", 32'(sig_b), 32'h01);
        check_eq("sig_loop2", 32'(sig_c), 32'h00);
        check_eq("vc_c", 32'(vc_c), 32'd2);
        check_eq("sig_settle", 32'(sig_d), 32'h00);
        check_eq("vc_settle", 32'(vc_d), 32'd2);
        check_eq("done_d", 32'(done_d), 32'h1);

        // seed 0 restart from DONE, then abort mid-run
        seed  = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("seed0_first", 32'(dut_in_a), 32'h01);
        check_eq("seed0_busy", 32'(busy_a), 32'h1);
        check_eq("seed0_done", 32'(done_a), 32'h0);
        tick();
        check_eq("seed0_second", 32'(dut_in_a), 32'hB8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy_a), 32'h0);
        check_eq("abort_done", 32'(done_a), 32'h0);
        check_eq("abort_dut_in", 32'(dut_in_a), 32'h0);
        check_eq("abort_sig", 32'(sig_a), 32'h36);
        check_eq("abort_vc", 32'(vc_a), 32'd1);
        tick();
        check_eq("abort_stays_idle", 32'(busy_a), 32'h0);

        // asynchronous reset in the middle of a run
        seed  = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("run2_first", 32'(dut_in_a), 32'h5A);
        tick();
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy_a), 32'h0);
        check_eq("arst_dut_in", 32'(dut_in_a), 32'h0);
        check_eq("arst_sig", 32'(sig_a), 32'h0);
        check_eq("arst_vc", 32'(vc_a), 32'h0);
        check_eq("arst_busy_d", 32'(busy_d), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
